// File: rtl/spi_cmd_ctrl.sv
// Command sequencer between the SPI slave word interface and the register bus.
// Latency: command word -> bus_req next cycle; bus_ack -> tx_valid next cycle.
// Backpressure: rx_ready low while a bus access or TX word is pending; words arriving then are dropped and flagged.
module spi_cmd_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              err_irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_BUS   = 2'd2,
    S_TXQ   = 2'd3
  } state_t;

  localparam logic [1:0]  OP_NOP    = 2'b00;
  localparam logic [1:0]  OP_WRITE  = 2'b01;
  localparam logic [1:0]  OP_READ   = 2'b10;
  localparam logic [1:0]  OP_STATUS = 2'b11;
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  // Registered state and outputs
  state_t            state, state_n;
  logic              cs_n_q;
  logic              discard, discard_n;
  logic [15:0]       cnt, cnt_n;
  logic              bus_we_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [31:0]       bus_wdata_n;
  logic [31:0]       tx_data_n;
  logic              err_ovr, err_ovr_n;
  logic              err_to, err_to_n;
  logic [7:0]        ovr_cnt, ovr_cnt_n;
  logic [7:0]        to_cnt, to_cnt_n;

  // Decode helpers
  logic              cs_rise;
  logic              ovr_set;
  logic              to_set;
  logic              clr;
  logic [1:0]        op;
  logic [31:0]       status_word;
  logic [7:0]        ovr_base, to_base;

  // Command bits between the CLR flag and the address field carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^rx_data[28:ADDR_W];

  assign cs_rise     = cs_n & ~cs_n_q;
  assign ovr_set     = rx_valid & ~rx_ready;
  assign op          = rx_data[31:30];
  assign status_word = {err_ovr, err_to, 14'b0, ovr_cnt, to_cnt};

  // Next-state decode: sequencing, bus handshake, timeout and frame-end handling
  always_comb begin
    state_n     = state;
    discard_n   = discard;
    cnt_n       = cnt;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    tx_data_n   = tx_data;
    to_set      = 1'b0;
    clr         = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          case (op)
            OP_WRITE: begin
              bus_addr_n = rx_data[ADDR_W-1:0];
              state_n    = S_WDATA;
            end
            OP_READ: begin
              bus_addr_n = rx_data[ADDR_W-1:0];
              bus_we_n   = 1'b0;
              cnt_n      = 16'd0;
              state_n    = S_BUS;
            end
            OP_STATUS: begin
              // Snapshot is taken from the pre-clear values.
              tx_data_n = status_word;
              clr       = rx_data[29];
              state_n   = S_TXQ;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end

      S_WDATA: begin
        // Frame end abandons a write whose data word never arrived.
        if (cs_rise) begin
          state_n = S_IDLE;
        end else if (rx_valid) begin
          bus_wdata_n = rx_data;
          bus_we_n    = 1'b1;
          cnt_n       = 16'd0;
          state_n     = S_BUS;
        end
      end

      S_BUS: begin
        // A frame end here only marks the result as unwanted; the access runs to completion.
        if (cs_rise) begin
          discard_n = 1'b1;
        end
        if (bus_ack) begin
          discard_n = 1'b0;
          if (bus_we || discard || cs_rise) begin
            state_n = S_IDLE;
          end else begin
            tx_data_n = bus_rdata;
            state_n   = S_TXQ;
          end
        end else if (cnt == TO_LAST) begin
          to_set    = 1'b1;
          discard_n = 1'b0;
          if (bus_we || discard || cs_rise) begin
            state_n = S_IDLE;
          end else begin
            tx_data_n = ERR_WORD;
            state_n   = S_TXQ;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      S_TXQ: begin
        if (cs_rise || tx_ready) begin
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Sticky error flags and saturating counters; a set in the clear cycle survives the clear
  always_comb begin
    ovr_base  = clr ? 8'd0 : ovr_cnt;
    to_base   = clr ? 8'd0 : to_cnt;
    err_ovr_n = (err_ovr & ~clr) | ovr_set;
    err_to_n  = (err_to & ~clr) | to_set;
    ovr_cnt_n = ovr_base;
    to_cnt_n  = to_base;
    if (ovr_set && (ovr_base != 8'hFF)) begin
      ovr_cnt_n = ovr_base + 8'd1;
    end
    if (to_set && (to_base != 8'hFF)) begin
      to_cnt_n = to_base + 8'd1;
    end
  end

  // State register; handshake outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cs_n_q    <= 1'b1;
      discard   <= 1'b0;
      cnt       <= 16'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 32'd0;
      tx_valid  <= 1'b0;
      tx_data   <= 32'd0;
      rx_ready  <= 1'b1;
      err_ovr   <= 1'b0;
      err_to    <= 1'b0;
      ovr_cnt   <= 8'd0;
      to_cnt    <= 8'd0;
      err_irq   <= 1'b0;
    end else begin
      state     <= state_n;
      cs_n_q    <= cs_n;
      discard   <= discard_n;
      cnt       <= cnt_n;
      bus_req   <= (state_n == S_BUS);
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      tx_valid  <= (state_n == S_TXQ);
      tx_data   <= tx_data_n;
      rx_ready  <= (state_n == S_IDLE) || (state_n == S_WDATA);
      err_ovr   <= err_ovr_n;
      err_to    <= err_to_n;
      ovr_cnt   <= ovr_cnt_n;
      to_cnt    <= to_cnt_n;
      err_irq   <= err_ovr_n | err_to_n;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: vector table for write/read, hand sequences for corner cases.
// Inputs change #1 after the rising edge; outputs are compared #1 after the next rising edge.
// TIMEOUT is set to 8 to keep timeout sequences short.
module tb_spi_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err_irq;

  int n_chk  = 0;
  int n_fail = 0;

  spi_cmd_ctrl #(.ADDR_W(8), .TIMEOUT(8), .ERR_WORD(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cs_n;
    logic        rxv;
    logic [31:0] rxd;
    logic        txr;
    logic        ack;
    logic [31:0] rdat;
    logic        e_req;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_txv;
    logic [31:0] e_txd;
    logic        e_rxr;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic cs, input logic rv, input logic [31:0] rd,
                     input logic tr, input logic ak, input logic [31:0] rdt,
                     input logic req, input logic we, input logic [7:0] ad, input logic [31:0] wd,
                     input logic txv, input logic [31:0] txd, input logic rxr, input logic irq);
    vec_t v;
    v.rst = r; v.cs_n = cs; v.rxv = rv; v.rxd = rd; v.txr = tr; v.ack = ak; v.rdat = rdt;
    v.e_req = req; v.e_we = we; v.e_addr = ad; v.e_wdata = wd;
    v.e_txv = txv; v.e_txd = txd; v.e_rxr = rxr; v.e_irq = irq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the given pulses; pulses are withdrawn after the edge.
  task automatic step(input logic rv, input logic [31:0] rd, input logic tr,
                      input logic ak, input logic [31:0] rdt);
    rx_valid  = rv;
    rx_data   = rd;
    tx_ready  = tr;
    bus_ack   = ak;
    bus_rdata = rdt;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    bus_ack  = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int cnt;
    string tag;
    rst = 1'b1; cs_n = 1'b1; rx_data = 32'h0; rx_valid = 1'b0;
    tx_ready = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;

    //   rst cs  rxv rxd           txr ack rdata          req we addr   wdata          txv txd            rxr irq
    add(1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 0);
    add(0, 0, 1, 32'h4000_0012, 0, 0, 32'h0,       0, 0, 8'h12, 32'h0,        0, 32'h0,        1, 0);
    add(0, 0, 1, 32'h1234_5678, 0, 0, 32'h0,       1, 1, 8'h12, 32'h1234_5678, 0, 32'h0,       0, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 8'h12, 32'h1234_5678, 0, 32'h0,       0, 0);
    add(0, 0, 0, 32'h0,        0, 1, 32'h0,        0, 1, 8'h12, 32'h1234_5678, 0, 32'h0,       1, 0);
    add(0, 0, 1, 32'h8000_0034, 0, 0, 32'h0,       1, 0, 8'h34, 32'h1234_5678, 0, 32'h0,       0, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 8'h34, 32'h1234_5678, 0, 32'h0,       0, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 8'h34, 32'h1234_5678, 0, 32'h0,       0, 0);
    add(0, 0, 0, 32'h0,        0, 1, 32'hCAFE_F00D, 0, 0, 8'h34, 32'h1234_5678, 1, 32'hCAFE_F00D, 0, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 8'h34, 32'h1234_5678, 1, 32'hCAFE_F00D, 0, 0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 8'h34, 32'h1234_5678, 0, 32'hCAFE_F00D, 1, 0);

    foreach (vecs[i]) begin
      rst  = vecs[i].rst;
      cs_n = vecs[i].cs_n;
      step(vecs[i].rxv, vecs[i].rxd, vecs[i].txr, vecs[i].ack, vecs[i].rdat);
      tag = $sformatf("vec%0d", i);
      chk({tag, " bus_req"},   bus_req,   vecs[i].e_req);
      chk({tag, " bus_we"},    bus_we,    vecs[i].e_we);
      chk({tag, " bus_addr"},  bus_addr,  vecs[i].e_addr);
      chk({tag, " bus_wdata"}, bus_wdata, vecs[i].e_wdata);
      chk({tag, " tx_valid"},  tx_valid,  vecs[i].e_txv);
      chk({tag, " tx_data"},   tx_data,   vecs[i].e_txd);
      chk({tag, " rx_ready"},  rx_ready,  vecs[i].e_rxr);
      chk({tag, " err_irq"},   err_irq,   vecs[i].e_irq);
    end

    // Ack arriving in the last allowed cycle beats the timeout.
    step(1'b1, 32'h8000_0021, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) idle();
    chk("edge_req_before_ack", bus_req, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_CAFE);
    chk("edge_txv", tx_valid, 1'b1);
    chk("edge_txd", tx_data, 32'h0BAD_CAFE);
    chk("edge_no_err", err_irq, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Overrun: word during BUS is dropped and flagged.
    step(1'b1, 32'h8000_0078, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h4000_00FF, 1'b0, 1'b0, 32'h0);
    chk("ovr_irq", err_irq, 1'b1);
    chk("ovr_still_bus", bus_req, 1'b1);
    chk("ovr_addr_kept", bus_addr, 8'h78);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'hE000_0000, 1'b0, 1'b0, 32'h0);
    chk("status_clr_txd", tx_data, 32'h8000_0100);
    chk("status_clr_txv", tx_valid, 1'b1);
    chk("status_clr_irq", err_irq, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Read timeout: bus_req high exactly TIMEOUT cycles, error word returned.
    step(1'b1, 32'h8000_0056, 1'b0, 1'b0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 20 && bus_req; i++) begin
      cnt++;
      idle();
    end
    chk("to_req_cycles", cnt, 8);
    chk("to_txv", tx_valid, 1'b1);
    chk("to_txd", tx_data, 32'hDEAD_BEEF);
    chk("to_irq", err_irq, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0);
    chk("status_keep_txd", tx_data, 32'h4000_0001);
    chk("status_keep_irq", err_irq, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("status_done_rxr", rx_ready, 1'b1);

    // Frame end between write command and data: no bus access.
    step(1'b1, 32'h4000_0099, 1'b0, 1'b0, 32'h0);
    cs_n = 1'b1;
    idle();
    cs_n = 1'b0;
    idle();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      if (bus_req) cnt++;
    end
    chk("csw_no_req", cnt, 0);
    chk("csw_rxr", rx_ready, 1'b1);

    // Frame end during BUS: access completes, read data discarded.
    step(1'b1, 32'h8000_00AB, 1'b0, 1'b0, 32'h0);
    cs_n = 1'b1;
    idle();
    chk("csb_req_held", bus_req, 1'b1);
    idle();
    chk("csb_req_held2", bus_req, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    chk("csb_req_off", bus_req, 1'b0);
    chk("csb_no_txv", tx_valid, 1'b0);
    chk("csb_rxr", rx_ready, 1'b1);
    idle();
    chk("csb_no_txv2", tx_valid, 1'b0);
    chk("csb_txd_kept", tx_data, 32'h4000_0001);
    cs_n = 1'b0;
    idle();

    // Reset while a TX word is pending.
    step(1'b1, 32'h8000_0042, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA);
    chk("rst_pre_txv", tx_valid, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 32'h0);
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 8'h00);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rxr", rx_ready, 1'b1);
    chk("rst_irq", err_irq, 1'b0);

    // Reset mid-BUS: request drops, no timeout flagged afterwards.
    step(1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0);
    chk("rstb_req_on", bus_req, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rstb_req_off", bus_req, 1'b0);
    for (int i = 0; i < 10; i++) idle();
    chk("rstb_no_err", err_irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
